apb_master: RTL

APB3 requester that turns single-word read/write commands from a local controller into APB transfers on the peripheral bus, and returns read data and an error status. It sits on the initiator side of the same bus that the register banks answer on. It drives PSEL/PENABLE/PADDR/PWDATA/PWRITE, honours PREADY wait states, reports PSLVERR, and can optionally abort a transfer that stalls.

---
 rtl/apb_master_pkg.sv | 15 +
 rtl/apb_master_if.sv | 43 ++++
 rtl/apb_master_timeout.sv | 27 ++
 rtl/apb_master.sv | 108 ++++++++++
 4 files changed

// File: rtl/apb_master_pkg.sv
// Shared types and default widths for the APB3 requester.
package apb_master_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    localparam int APB_ADDR_WIDTH_DEF = 12;
    localparam int APB_DATA_WIDTH_DEF = 32;
    localparam int TIMEOUT_CYCLES_DEF = 16;

endpackage

// File: rtl/apb_master_if.sv
// Command/response handshake plus APB3 bus signals of the requester.
// Both handshakes are strict valid/ready: a beat transfers on a rising edge
// where valid and ready are both high; valid, once raised, holds with its payload until then.
interface apb_master_if #(
    parameter int APB_ADDR_WIDTH = apb_master_pkg::APB_ADDR_WIDTH_DEF,
    parameter int APB_DATA_WIDTH = apb_master_pkg::APB_DATA_WIDTH_DEF
);
    logic                      i_req_valid;
    logic                      o_req_ready;
    logic                      i_req_write;
    logic [APB_ADDR_WIDTH-1:0] i_req_addr;
    logic [APB_DATA_WIDTH-1:0] i_req_wdata;

    logic                      o_rsp_valid;
    logic                      i_rsp_ready;
    logic [APB_DATA_WIDTH-1:0] o_rsp_rdata;
    logic                      o_rsp_err;
    logic                      o_rsp_timeout;

    logic [APB_ADDR_WIDTH-1:0] o_PADDR;
    logic [APB_DATA_WIDTH-1:0] o_PWDATA;
    logic                      o_PWRITE;
    logic                      o_PSEL;
    logic                      o_PENABLE;
    logic [APB_DATA_WIDTH-1:0] i_PRDATA;
    logic                      i_PREADY;
    logic                      i_PSLVERR;

    modport master (
        input  i_req_valid, i_req_write, i_req_addr, i_req_wdata, i_rsp_ready,
               i_PRDATA, i_PREADY, i_PSLVERR,
        output o_req_ready, o_rsp_valid, o_rsp_rdata, o_rsp_err, o_rsp_timeout,
               o_PADDR, o_PWDATA, o_PWRITE, o_PSEL, o_PENABLE
    );

    modport slave (
        output i_req_valid, i_req_write, i_req_addr, i_req_wdata, i_rsp_ready,
               i_PRDATA, i_PREADY, i_PSLVERR,
        input  o_req_ready, o_rsp_valid, o_rsp_rdata, o_rsp_err, o_rsp_timeout,
               o_PADDR, o_PWDATA, o_PWRITE, o_PSEL, o_PENABLE
    );

endinterface

// File: rtl/apb_master_timeout.sv
// ACCESS-phase wait counter; expired flags the last permitted stalled cycle.
module apb_master_timeout #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic HCLK,
    input  logic HRESETn,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CW-1:0] count;

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !expired) begin
            count <= count + 1'b1;
        end
    end

    assign expired = (count == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/apb_master.sv
// APB3 requester: one outstanding single-word transfer, IDLE/SETUP/ACCESS/RESP.
// Stalled-transfer abort is built only when APB_MASTER_TIMEOUT_EN is defined.
module apb_master
    import apb_master_pkg::*;
#(
    parameter int APB_ADDR_WIDTH = APB_ADDR_WIDTH_DEF,
    parameter int APB_DATA_WIDTH = APB_DATA_WIDTH_DEF,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic          HCLK,
    input  logic          HRESETn,
    apb_master_if.master  bus,
    output state_t        dbg_state
);
    state_t state;
    logic   abort;

`ifdef APB_MASTER_TIMEOUT_EN
    logic wait_clear;
    logic wait_en;
    logic wait_expired;

    // Counter restarts during SETUP so the first ACCESS cycle sees zero.
    assign wait_clear = (state == SETUP);
    assign wait_en    = (state == ACCESS) && !bus.i_PREADY;

    apb_master_timeout #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .HCLK    (HCLK),
        .HRESETn (HRESETn),
        .clear   (wait_clear),
        .enable  (wait_en),
        .expired (wait_expired)
    );

    assign abort = wait_en && wait_expired;
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES < 2);
    assign abort = 1'b0;
`endif

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            state             <= IDLE;
            bus.o_req_ready   <= 1'b1;
            bus.o_PSEL        <= 1'b0;
            bus.o_PENABLE     <= 1'b0;
            bus.o_PWRITE      <= 1'b0;
            bus.o_PADDR       <= {APB_ADDR_WIDTH{1'b0}};
            bus.o_PWDATA      <= {APB_DATA_WIDTH{1'b0}};
            bus.o_rsp_valid   <= 1'b0;
            bus.o_rsp_rdata   <= {APB_DATA_WIDTH{1'b0}};
            bus.o_rsp_err     <= 1'b0;
            bus.o_rsp_timeout <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.i_req_valid) begin
                        bus.o_PADDR     <= bus.i_req_addr;
                        bus.o_PWRITE    <= bus.i_req_write;
                        bus.o_PWDATA    <= bus.i_req_write ? bus.i_req_wdata
                                                           : {APB_DATA_WIDTH{1'b0}};
                        bus.o_PSEL      <= 1'b1;
                        bus.o_req_ready <= 1'b0;
                        state           <= SETUP;
                    end
                end
                SETUP: begin
                    bus.o_PENABLE <= 1'b1;
                    state         <= ACCESS;
                end
                ACCESS: begin
                    // Normal completion takes priority over an abort in the same cycle.
                    if (bus.i_PREADY) begin
                        bus.o_rsp_rdata   <= bus.o_PWRITE ? {APB_DATA_WIDTH{1'b0}} : bus.i_PRDATA;
                        bus.o_rsp_err     <= bus.i_PSLVERR;
                        bus.o_rsp_timeout <= 1'b0;
                        bus.o_PSEL        <= 1'b0;
                        bus.o_PENABLE     <= 1'b0;
                        bus.o_rsp_valid   <= 1'b1;
                        state             <= RESP;
                    end else if (abort) begin
                        bus.o_rsp_rdata   <= {APB_DATA_WIDTH{1'b0}};
                        bus.o_rsp_err     <= 1'b1;
                        bus.o_rsp_timeout <= 1'b1;
                        bus.o_PSEL        <= 1'b0;
                        bus.o_PENABLE     <= 1'b0;
                        bus.o_rsp_valid   <= 1'b1;
                        state             <= RESP;
                    end
                end
                RESP: begin
                    if (bus.i_rsp_ready) begin
                        bus.o_rsp_valid <= 1'b0;
                        bus.o_req_ready <= 1'b1;
                        state           <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign dbg_state = state;

endmodule
